// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache tag store: geometry helpers,
// entry field positions and the controller state type.
package cache_pkg;

    typedef enum logic {StInit, StReady} tag_state_e;

    function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned index_w,
                                          input int unsigned offset_w);
        return addr_w - index_w - offset_w;
    endfunction

    function automatic int unsigned line_bytes(input int unsigned offset_w);
        return 1 << offset_w;
    endfunction

    // One bit is kept even for WAYS=1 so the storage never has zero width.
    function automatic int unsigned plru_w(input int unsigned ways);
        return (ways > 1) ? ways - 1 : 1;
    endfunction

    function automatic int unsigned entry_w(input int unsigned tw);
        return tw + 2;
    endfunction

    function automatic int unsigned entry_valid_bit(input int unsigned tw);
        return tw + 1;
    endfunction

    function automatic int unsigned entry_dirty_bit(input int unsigned tw);
        return tw;
    endfunction

endpackage

// File: rtl/cache_tag_assoc_plru.sv
// Tree pseudo-LRU for one set: next state after an access and the current victim.
module cache_tag_assoc_plru
    import cache_pkg::*;
#(
    parameter int unsigned WAYS = 2,
    parameter int unsigned PW   = plru_w(WAYS)
) (
    input  logic [PW-1:0]   plru_cur,
    input  logic [WAYS-1:0] access_way,
    output logic [PW-1:0]   plru_next,
    output logic [WAYS-1:0] victim
);

    generate
        if (WAYS == 4) begin : g_four
            always_comb begin
                plru_next = plru_cur;
                unique case (access_way)
                    4'b0001: begin plru_next[0] = 1'b1; plru_next[1] = 1'b1; end
                    4'b0010: begin plru_next[0] = 1'b1; plru_next[1] = 1'b0; end
                    4'b0100: begin plru_next[0] = 1'b0; plru_next[2] = 1'b1; end
                    4'b1000: begin plru_next[0] = 1'b0; plru_next[2] = 1'b0; end
                    default: ;
                endcase
            end

            always_comb begin
                victim = '0;
                if (!plru_cur[0]) victim[plru_cur[1] ? 1 : 0] = 1'b1;
                else              victim[plru_cur[2] ? 3 : 2] = 1'b1;
            end
        end else if (WAYS == 2) begin : g_two
            // The bit names the least recently used way.
            always_comb begin
                plru_next = plru_cur;
                if (access_way[0])      plru_next[0] = 1'b1;
                else if (access_way[1]) plru_next[0] = 1'b0;
            end

            assign victim = plru_cur[0] ? 2'b10 : 2'b01;
        end else begin : g_one
            assign plru_next = plru_cur;
            assign victim    = WAYS'(1);
        end
    endgenerate

endmodule

// File: rtl/cache_tag_assoc.sv
// Set-associative tag store with pseudo-LRU replacement, dirty write-back
// detection and a post-reset invalidate sweep over every set.
module cache_tag_assoc
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned INDEX_WIDTH  = 7,
    parameter int unsigned OFFSET_WIDTH = 5,
    parameter int unsigned WAYS         = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cached,
    input  logic                  sram_en,
    input  logic [3:0]            sram_wen,
    input  logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic                  refresh,
    output logic                  stallreq,
    output logic                  hit,
    output logic [WAYS-1:0]       hit_way,
    output logic                  miss,
    output logic [WAYS-1:0]       victim_way,
    output logic [ADDR_WIDTH-1:0] axi_raddr,
    output logic                  write_back,
    output logic [ADDR_WIDTH-1:0] axi_waddr,
    output logic                  init_busy
);

    localparam int unsigned TAG_W = tag_w(ADDR_WIDTH, INDEX_WIDTH, OFFSET_WIDTH);
    localparam int unsigned SETS  = 1 << INDEX_WIDTH;
    localparam int unsigned PW    = plru_w(WAYS);
    localparam int unsigned EW    = entry_w(TAG_W);
    localparam int unsigned VB    = entry_valid_bit(TAG_W);
    localparam int unsigned DB    = entry_dirty_bit(TAG_W);

    logic [EW-1:0] entry_q [SETS][WAYS];
    logic [PW-1:0] plru_q  [SETS];

    tag_state_e             state_q, state_d;
    logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;

    logic [TAG_W-1:0]       tag;
    logic [INDEX_WIDTH-1:0] idx;
    logic                   ready, lookup, any_match;
    logic [WAYS-1:0]        way_valid, way_dirty, match, invalid, lowest_inv;
    logic [WAYS-1:0]        plru_victim, access_way;
    logic [PW-1:0]          plru_next;
    logic [TAG_W-1:0]       victim_tag;

    assign tag   = sram_addr[ADDR_WIDTH-1 -: TAG_W];
    assign idx   = sram_addr[OFFSET_WIDTH +: INDEX_WIDTH];
    assign ready = (state_q == StReady);

    always_comb begin
        way_valid = '0;
        way_dirty = '0;
        match     = '0;
        for (int w = 0; w < WAYS; w++) begin
            way_valid[w] = entry_q[idx][w][VB];
            way_dirty[w] = entry_q[idx][w][DB];
            match[w]     = way_valid[w] && (entry_q[idx][w][TAG_W-1:0] == tag);
        end
    end

    assign invalid    = ~way_valid;
    assign lowest_inv = invalid & (~invalid + WAYS'(1));
    assign any_match  = |match;
    assign lookup     = ready & cached & sram_en;
    assign hit        = lookup & any_match;
    assign miss       = lookup & ~any_match;
    assign hit_way    = hit ? match : '0;
    assign victim_way = !ready ? WAYS'(1) : ((|invalid) ? lowest_inv : plru_victim);
    assign write_back = miss & (|(victim_way & way_valid & way_dirty));
    assign stallreq   = ~ready | miss;
    assign init_busy  = ~ready;
    assign access_way = hit ? match : victim_way;

    always_comb begin
        victim_tag = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (victim_way[w]) victim_tag |= entry_q[idx][w][TAG_W-1:0];
        end
    end

    assign axi_waddr = {victim_tag, idx, {OFFSET_WIDTH{1'b0}}};
    assign axi_raddr = cached ? {sram_addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}}
                              : sram_addr;

    cache_tag_assoc_plru #(
        .WAYS (WAYS),
        .PW   (PW)
    ) u_plru (
        .plru_cur   (plru_q[idx]),
        .access_way (access_way),
        .plru_next  (plru_next),
        .victim     (plru_victim)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == INDEX_WIDTH'(SETS - 1)) state_d = StReady;
            end
            StReady: ;
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Tags are left alone by reset; the sweep only needs to clear valid, dirty and PLRU.
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (!ready) begin
                for (int w = 0; w < WAYS; w++) begin
                    entry_q[cnt_q][w][VB] <= 1'b0;
                    entry_q[cnt_q][w][DB] <= 1'b0;
                end
                plru_q[cnt_q] <= '0;
            end else if (hit) begin
                plru_q[idx] <= plru_next;
                if (|sram_wen) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (hit_way[w]) entry_q[idx][w][DB] <= 1'b1;
                    end
                end
            end else if (miss && refresh) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (victim_way[w]) entry_q[idx][w] <= {1'b1, |sram_wen, tag};
                end
                plru_q[idx] <= plru_next;
            end
        end
    end

endmodule
